dmem_mmio_responder: RTL

Data-side responder for the pipelined RISC-V core: the slave end of its DM port (`mem_w`, `wea`, address, write data, read data). Decodes every MEM-stage access into a byte-lane-writable word RAM or a small MMIO register file: LEDs, synchronized switches, a 64-bit cycle counter and a compare timer with an interrupt flag. Read data is returned combinationally in the same cycle, because the core captures it into MEM/WB at the next edge. Writes commit on the clock edge.

---
 rtl/dmem_mmio_responder_pkg.sv | 19 +
 rtl/dm_ram.sv | 26 ++
 rtl/dmem_mmio_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory / MMIO responder: register offsets,
// TCTRL bit positions and the default MMIO page base.
package dmem_mmio_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_F000;

  localparam logic [11:0] IO_LED   = 12'h000;
  localparam logic [11:0] IO_SW    = 12'h004;
  localparam logic [11:0] IO_CNTLO = 12'h008;
  localparam logic [11:0] IO_CNTHI = 12'h00C;
  localparam logic [11:0] IO_TCMP  = 12'h010;
  localparam logic [11:0] IO_TVAL  = 12'h014;
  localparam logic [11:0] IO_TCTRL = 12'h018;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_PEND = 1;
  localparam int TCTRL_IE   = 2;

endpackage

// File: rtl/dm_ram.sv
// Word RAM with per-byte-lane synchronous write and asynchronous read.
// Contents are never reset.
module dm_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Commit each enabled byte lane on the rising edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read returns the pre-edge contents, so a same-cycle read sees old data
  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_mmio_responder.sv
// DM-port slave for the pipelined core: decodes each access into the word RAM
// or the MMIO page (LEDs, synchronized switches, cycle counter, compare timer).
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          IO_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_w,
  input  logic [3:0]      wea,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_wdata,
  output logic [31:0]     cpu_rdata,
  input  logic [IO_W-1:0] sw_i,
  output logic [IO_W-1:0] led_o,
  output logic            irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic            ram_sel, mmio_sel, mmio_wr;
  logic            wr_led, wr_tcmp, wr_tctrl, match;
  logic [11:0]     off;
  logic [3:0]      ram_we;
  logic [31:0]     ram_rdata;
  logic [IO_W-1:0] led, sw_s1, sw_s2;
  logic [63:0]     cnt;
  logic [31:0]     tcmp, tval;
  logic            en, pend, ie;

  assign ram_sel  = (cpu_addr[31:AW+2] == '0);
  assign mmio_sel = (cpu_addr[31:12] == MMIO_BASE[31:12]);
  assign off      = cpu_addr[11:0];

  // RAM ignores reset, so a write in the reset cycle still lands
  assign ram_we   = (mem_w && ram_sel) ? wea : 4'h0;
  // MMIO registers only accept full-word stores
  assign mmio_wr  = mem_w && mmio_sel && (wea == 4'hF);
  assign wr_led   = mmio_wr && (off == IO_LED);
  assign wr_tcmp  = mmio_wr && (off == IO_TCMP);
  assign wr_tctrl = mmio_wr && (off == IO_TCTRL);
  assign match    = en && (tval == tcmp);

  dm_ram #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cpu_addr[AW+1:2]),
    .wdata (cpu_wdata),
    .rdata (ram_rdata)
  );

  // MMIO state: LED, switch synchronizer, cycle counter and timer
  always_ff @(posedge clk) begin
    if (reset) begin
      led   <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      cnt   <= '0;
      tcmp  <= '0;
      tval  <= '0;
      en    <= 1'b0;
      pend  <= 1'b0;
      ie    <= 1'b0;
    end else begin
      sw_s1 <= sw_i;
      sw_s2 <= sw_s1;
      cnt   <= cnt + 64'd1;
      if (wr_led)  led  <= cpu_wdata[IO_W-1:0];
      if (wr_tcmp) tcmp <= cpu_wdata;
      // A compare write restarts the period; a match wraps it
      if (wr_tcmp || match) tval <= '0;
      else if (en)          tval <= tval + 32'd1;
      // Match beats a simultaneous write-1-to-clear
      if (match)                                      pend <= 1'b1;
      else if (wr_tctrl && cpu_wdata[TCTRL_PEND])     pend <= 1'b0;
      if (wr_tctrl) begin
        en <= cpu_wdata[TCTRL_EN];
        ie <= cpu_wdata[TCTRL_IE];
      end
    end
  end

  // Combinational read mux; unmapped addresses and offsets read zero
  always_comb begin
    cpu_rdata = '0;
    if (ram_sel) begin
      cpu_rdata = ram_rdata;
    end else if (mmio_sel) begin
      case (off)
        IO_LED:   cpu_rdata[IO_W-1:0] = led;
        IO_SW:    cpu_rdata[IO_W-1:0] = sw_s2;
        IO_CNTLO: cpu_rdata = cnt[31:0];
        IO_CNTHI: cpu_rdata = cnt[63:32];
        IO_TCMP:  cpu_rdata = tcmp;
        IO_TVAL:  cpu_rdata = tval;
        IO_TCTRL: begin
          cpu_rdata[TCTRL_EN]   = en;
          cpu_rdata[TCTRL_PEND] = pend;
          cpu_rdata[TCTRL_IE]   = ie;
        end
        default: cpu_rdata = '0;
      endcase
    end
  end

  assign led_o = led;
  assign irq   = pend & ie;

endmodule
